// File: rtl/reg_bank_responder.sv
// reg_bank_responder: responder end of a 4-phase req/ack register bank.
// Each request gets one read or write, then ack, then one dead RELEASE cycle.
module reg_bank_responder #(
    parameter int              Size       = 16,
    parameter int              Depth      = 8,
    parameter int              AddrWidth  = 3,
    parameter logic [Size-1:0] ResetValue = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [Size-1:0]      i_wdata,
    output logic                 o_ack,
    output logic [Size-1:0]      o_rdata,
    output logic                 o_err
);
    typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

    state_t          r_state;
    logic [Size-1:0] r_regs [Depth];
    logic            w_valid;

    assign w_valid = int'(i_addr) < Depth;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            o_ack   <= 1'b0;
            o_err   <= 1'b0;
            o_rdata <= '0;
            for (int i = 0; i < Depth; i++) r_regs[i] <= ResetValue;
        end else begin
            case (r_state)
                IDLE: if (i_req) begin
                    r_state <= ACK;
                    o_ack   <= 1'b1;
                    o_err   <= !w_valid;
                    o_rdata <= !w_valid ? '0 : i_we ? i_wdata : r_regs[i_addr];
                    if (w_valid && i_we) r_regs[i_addr] <= i_wdata;
                end
                ACK: if (!i_req) begin
                    r_state <= RELEASE;
                    o_ack   <= 1'b0;
                end
                // RELEASE ignores req so back-to-back requests see a dead cycle
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
